// File: rtl/way_alloc_ctrl.sv
// way_alloc_ctrl: 4-way set-associative tag/valid/age store with a
// lookup -> fill -> update controller. One request is outstanding at a
// time, so a request always sees every update made by the ones before it.
// Optional build macro: WAY_ALLOC_STATS_EN adds saturating 16-bit
// hit_cnt / miss_cnt counters for access requests.
module way_alloc_ctrl #(
    parameter int SETS  = 16,
    parameter int TAG_W = 12,
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_op,
    output logic             fill_req,
    output logic [1:0]       fill_way,
    input  logic             fill_done,
    output logic             evict_valid,
    output logic [TAG_W-1:0] evict_tag,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [1:0]       resp_way
`ifdef WAY_ALLOC_STATS_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [TAG_W-1:0]   lat_tag_q, lat_tag_d;
    logic               op_q, op_d;
    logic               hit_q, hit_d;
    logic [1:0]         way_q, way_d;
    logic               ev_valid_q, ev_valid_d;
    logic [TAG_W-1:0]   ev_tag_q, ev_tag_d;

    logic               valid_q [SETS][4];
    logic               valid_d [SETS][4];
    logic [TAG_W-1:0]   tags_q  [SETS][4];
    logic [TAG_W-1:0]   tags_d  [SETS][4];
    logic [1:0]         age_q   [SETS][4];
    logic [1:0]         age_d   [SETS][4];

`ifdef WAY_ALLOC_STATS_EN
    logic [15:0]        hit_cnt_q, hit_cnt_d;
    logic [15:0]        miss_cnt_q, miss_cnt_d;
`endif

    logic               hit_found;
    logic [1:0]         hit_way;
    logic               inv_found;
    logic [1:0]         inv_way;
    logic [1:0]         lru_way;
    logic [1:0]         victim;
    logic [1:0]         old_age;

    // Tag match and victim choice for the latched set (lowest index wins).
    always_comb begin
        hit_found = 1'b0;
        hit_way   = 2'd0;
        inv_found = 1'b0;
        inv_way   = 2'd0;
        lru_way   = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (valid_q[set_q][w] && (tags_q[set_q][w] == lat_tag_q)) begin
                hit_found = 1'b1;
                hit_way   = 2'(w);
            end
            if (!valid_q[set_q][w]) begin
                inv_found = 1'b1;
                inv_way   = 2'(w);
            end
            if (age_q[set_q][w] == 2'd3) begin
                lru_way = 2'(w);
            end
        end
        victim  = inv_found ? inv_way : lru_way;
        old_age = age_q[set_q][way_q];
    end

    // Next-state logic: controller sequencing plus store and age updates.
    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        lat_tag_d  = lat_tag_q;
        op_d       = op_q;
        hit_d      = hit_q;
        way_d      = way_q;
        ev_valid_d = ev_valid_q;
        ev_tag_d   = ev_tag_q;
        valid_d    = valid_q;
        tags_d     = tags_q;
        age_d      = age_q;
`ifdef WAY_ALLOC_STATS_EN
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    set_d     = req_set;
                    lat_tag_d = req_tag;
                    op_d      = req_op;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_found) begin
                    hit_d   = 1'b1;
                    way_d   = hit_way;
                    state_d = UPDATE;
                end else if (op_q) begin
                    hit_d   = 1'b0;
                    way_d   = 2'd0;
                    state_d = UPDATE;
                end else begin
                    hit_d      = 1'b0;
                    way_d      = victim;
                    ev_valid_d = valid_q[set_q][victim];
                    ev_tag_d   = tags_q[set_q][victim];
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    tags_d[set_q][way_q]  = lat_tag_q;
                    valid_d[set_q][way_q] = 1'b1;
                    state_d               = UPDATE;
                end
            end
            UPDATE: begin
                if (op_q) begin
                    if (hit_q) begin
                        valid_d[set_q][way_q] = 1'b0;
                    end
                end else begin
                    for (int w = 0; w < 4; w++) begin
                        if (2'(w) == way_q) begin
                            age_d[set_q][w] = 2'd0;
                        end else if (age_q[set_q][w] < old_age) begin
                            age_d[set_q][w] = age_q[set_q][w] + 2'd1;
                        end
                    end
`ifdef WAY_ALLOC_STATS_EN
                    if (hit_q) begin
                        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                    end else begin
                        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                    end
`endif
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset empties every set and seeds ages 0,1,2,3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            set_q      <= '0;
            lat_tag_q  <= '0;
            op_q       <= 1'b0;
            hit_q      <= 1'b0;
            way_q      <= 2'd0;
            ev_valid_q <= 1'b0;
            ev_tag_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < 4; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tags_q[s][w]  <= '0;
                    age_q[s][w]   <= 2'(w);
                end
            end
`ifdef WAY_ALLOC_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            lat_tag_q  <= lat_tag_d;
            op_q       <= op_d;
            hit_q      <= hit_d;
            way_q      <= way_d;
            ev_valid_q <= ev_valid_d;
            ev_tag_q   <= ev_tag_d;
            valid_q    <= valid_d;
            tags_q     <= tags_d;
            age_q      <= age_d;
`ifdef WAY_ALLOC_STATS_EN
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`endif
        end
    end

    // Outputs decode from the state so they read zero outside their phase.
    always_comb begin
        req_ready   = (state_q == IDLE);
        fill_req    = (state_q == FILL);
        fill_way    = fill_req ? way_q : 2'd0;
        evict_valid = fill_req & ev_valid_q;
        evict_tag   = fill_req ? ev_tag_q : '0;
        resp_valid  = (state_q == UPDATE);
        resp_hit    = resp_valid & hit_q;
        resp_way    = resp_valid ? way_q : 2'd0;
    end

`ifdef WAY_ALLOC_STATS_EN
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_way_alloc_ctrl.sv
// Testbench for way_alloc_ctrl: directed vector table, a reset-during-fill
// sequence, then random traffic checked against a recency-list model.
module tb_way_alloc_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_set;
    logic [11:0] req_tag;
    logic        req_op;
    logic        fill_req;
    logic [1:0]  fill_way;
    logic        fill_done;
    logic        evict_valid;
    logic [11:0] evict_tag;
    logic        resp_valid;
    logic        resp_hit;
    logic [1:0]  resp_way;
`ifdef WAY_ALLOC_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    way_alloc_ctrl #(.SETS(16), .TAG_W(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_set(req_set), .req_tag(req_tag), .req_op(req_op),
        .fill_req(fill_req), .fill_way(fill_way), .fill_done(fill_done),
        .evict_valid(evict_valid), .evict_tag(evict_tag),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way)
`ifdef WAY_ALLOC_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: per-set recency list (index 0 = most recent way)
    bit          m_valid [16][4];
    logic [11:0] m_tag   [16][4];
    int          m_rec   [16][4];
    int          m_hits;
    int          m_misses;

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = 12'h000;
                m_rec[s][w]   = w;
            end
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_touch(input int s, input int way);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) if (m_rec[s][i] == way) p = i;
        for (int i = p; i > 0; i--) m_rec[s][i] = m_rec[s][i-1];
        m_rec[s][0] = way;
    endtask

    task automatic model_step(input int s, input logic [11:0] tag, input bit op,
                              output bit hit, output logic [1:0] way, output bit fill,
                              output bit ev_valid, output logic [11:0] ev_tag);
        int  w_sel;
        bit  found;
        hit = 0; w_sel = 0; fill = 0; ev_valid = 0; ev_tag = 12'h000;
        for (int w = 0; w < 4; w++) begin
            if (!hit && m_valid[s][w] && m_tag[s][w] == tag) begin
                hit = 1; w_sel = w;
            end
        end
        if (op) begin
            if (hit) m_valid[s][w_sel] = 1'b0;
            else w_sel = 0;
        end else begin
            if (!hit) begin
                fill  = 1;
                found = 0;
                for (int w = 0; w < 4; w++) begin
                    if (!found && !m_valid[s][w]) begin
                        found = 1; w_sel = w;
                    end
                end
                if (!found) w_sel = m_rec[s][3];
                ev_valid = m_valid[s][w_sel];
                ev_tag   = m_tag[s][w_sel];
                m_tag[s][w_sel]   = tag;
                m_valid[s][w_sel] = 1'b1;
                m_misses++;
            end else begin
                m_hits++;
            end
            model_touch(s, w_sel);
        end
        way = 2'(w_sel);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one request from IDLE to its completion and checks every phase.
    task automatic applyStimulus(input logic [3:0] s, input logic [11:0] tag, input bit op,
                                 input int delay, input bit noise,
                                 input bit e_hit, input logic [1:0] e_way, input bit e_fill,
                                 input bit e_ev_valid, input logic [11:0] e_ev_tag);
        checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_set   = s;
        req_tag   = tag;
        req_op    = op;
        fill_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        fill_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        checkOutput("lookup_quiet", {30'd0, resp_valid, fill_req}, 32'd0);
        @(posedge clk); #1;
        if (e_fill) begin
            checkOutput("fill_req", {31'd0, fill_req}, 32'd1);
            checkOutput("fill_way", {30'd0, fill_way}, {30'd0, e_way});
            checkOutput("evict_valid", {31'd0, evict_valid}, {31'd0, e_ev_valid});
            checkOutput("evict_tag", {20'd0, evict_tag}, {20'd0, e_ev_tag});
            for (int i = 0; i < delay; i++) begin
                fill_done = 1'b0;
                @(posedge clk); #1;
                checkOutput("fill_stable", {16'd0, resp_valid, fill_req, fill_way, evict_valid, evict_tag},
                            {16'd0, 1'b0, 1'b1, e_way, e_ev_valid, e_ev_tag});
            end
            fill_done = 1'b1;
            @(posedge clk); #1;
            fill_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
            checkOutput("no_fill", {31'd0, fill_req}, 32'd0);
        end
        checkOutput("resp_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("resp_hit", {31'd0, resp_hit}, {31'd0, e_hit});
        checkOutput("resp_way", {30'd0, resp_way}, {30'd0, e_way});
        @(posedge clk); #1;
        fill_done = 1'b0;
        checkOutput("resp_pulse_end", {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  set;
        logic [11:0] tag;
        bit          op;
        int          delay;
        bit          hit;
        logic [1:0]  way;
        bit          fill;
        bit          ev_valid;
        logic [11:0] ev_tag;
    } vec_t;

    vec_t vecs [11];

    // Global watchdog
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit          m_hit, m_fill, m_evv;
        logic [1:0]  m_way;
        logic [11:0] m_evt;
        logic [3:0]  r_set;
        logic [11:0] r_tag;
        bit          r_op;

        vecs[0]  = '{4'd3, 12'h0A5, 1'b0, 1, 1'b0, 2'd0, 1'b1, 1'b0, 12'h000};
        vecs[1]  = '{4'd3, 12'h0A5, 1'b0, 0, 1'b1, 2'd0, 1'b0, 1'b0, 12'h000};
        vecs[2]  = '{4'd5, 12'h001, 1'b0, 0, 1'b0, 2'd0, 1'b1, 1'b0, 12'h000};
        vecs[3]  = '{4'd5, 12'h002, 1'b0, 2, 1'b0, 2'd1, 1'b1, 1'b0, 12'h000};
        vecs[4]  = '{4'd5, 12'h003, 1'b0, 0, 1'b0, 2'd2, 1'b1, 1'b0, 12'h000};
        vecs[5]  = '{4'd5, 12'h004, 1'b0, 1, 1'b0, 2'd3, 1'b1, 1'b0, 12'h000};
        vecs[6]  = '{4'd5, 12'h001, 1'b0, 0, 1'b1, 2'd0, 1'b0, 1'b0, 12'h000};
        vecs[7]  = '{4'd5, 12'h005, 1'b0, 0, 1'b0, 2'd1, 1'b1, 1'b1, 12'h002};
        vecs[8]  = '{4'd5, 12'h003, 1'b1, 0, 1'b1, 2'd2, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{4'd5, 12'h009, 1'b0, 0, 1'b0, 2'd2, 1'b1, 1'b0, 12'h003};
        vecs[10] = '{4'd5, 12'h7FF, 1'b1, 0, 1'b0, 2'd0, 1'b0, 1'b0, 12'h000};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_set   = 4'd0;
        req_tag   = 12'h000;
        req_op    = 1'b0;
        fill_done = 1'b0;
        model_reset();

        @(posedge clk); #1;
        checkOutput("reset_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_outputs", {11'd0, fill_req, evict_valid, resp_valid, resp_hit,
                                      fill_way, resp_way, evict_tag}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 11; i++) begin
            model_step(int'(vecs[i].set), vecs[i].tag, vecs[i].op, m_hit, m_way, m_fill, m_evv, m_evt);
            applyStimulus(vecs[i].set, vecs[i].tag, vecs[i].op, vecs[i].delay, 1'b0,
                          vecs[i].hit, vecs[i].way, vecs[i].fill, vecs[i].ev_valid, vecs[i].ev_tag);
`ifdef WAY_ALLOC_STATS_EN
            if (i == 1) begin
                checkOutput("hit_cnt_first_pair", {16'd0, hit_cnt}, 32'd1);
                checkOutput("miss_cnt_first_pair", {16'd0, miss_cnt}, 32'd1);
            end
`endif
        end

        $display("[TB] reset during fill");
        req_valid = 1'b1;
        req_set   = 4'd5;
        req_tag   = 12'h100;
        req_op    = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("midfill_fill_req", {31'd0, fill_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midfill_drop", {29'd0, fill_req, resp_valid, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("midfill_no_resp", {30'd0, resp_valid, fill_req}, 32'd0);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        model_step(5, 12'h100, 1'b0, m_hit, m_way, m_fill, m_evv, m_evt);
        checkOutput("reaccess_misses", {31'd0, m_fill}, 32'd1);
        applyStimulus(4'd5, 12'h100, 1'b0, 0, 1'b0, m_hit, m_way, m_fill, m_evv, m_evt);

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            r_set = 4'($urandom_range(0, 3));
            r_tag = 12'($urandom_range(0, 7) * 3 + 1);
            r_op  = ($urandom_range(0, 4) == 0);
            model_step(int'(r_set), r_tag, r_op, m_hit, m_way, m_fill, m_evv, m_evt);
            applyStimulus(r_set, r_tag, r_op, int'($urandom_range(0, 3)), 1'b1,
                          m_hit, m_way, m_fill, m_evv, m_evt);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

`ifdef WAY_ALLOC_STATS_EN
        checkOutput("hit_cnt_final", {16'd0, hit_cnt}, 32'(m_hits));
        checkOutput("miss_cnt_final", {16'd0, miss_cnt}, 32'(m_misses));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/way_alloc_ctrl.md
WAY_ALLOC_CTRL -- requirements
Module: way_alloc_ctrl

Interface
REQ-001 The block SHALL have parameter SETS, default 16, number of cache sets (power of two, 2..256).
REQ-002 The block SHALL have parameter TAG_W, default 12, tag width in bits; associativity SHALL be fixed at 4 ways.
REQ-003 The block SHALL have port clk, input, 1, the only clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have req_valid/req_ready, input/output, 1 each, request handshake; transfer occurs when both are high on a clk edge.
REQ-006 The block SHALL have req_set (input, log2(SETS)), req_tag (input, TAG_W) and req_op (input, 1: 0=access, 1=invalidate).
REQ-007 The block SHALL have fill_req (output, 1), fill_way (output, 2) and fill_done (input, 1), the miss-fill handshake.
REQ-008 The block SHALL have evict_valid (output, 1) and evict_tag (output, TAG_W), which identify the displaced line during a fill.
REQ-009 The block SHALL have resp_valid, resp_hit (output, 1 each) and resp_way (output, 2), the per-request completion.

Function
REQ-010 The block SHALL hold, per set and way, a valid bit, a TAG_W tag and a 2-bit age (0=MRU, 3=LRU); the ages within a set SHALL always be a permutation of 0..3.
REQ-011 The FSM SHALL have states IDLE, LOOKUP, FILL and UPDATE; req_ready SHALL be 1 only in IDLE.
REQ-012 In IDLE, an accepted request SHALL latch set/tag/op and move to LOOKUP on the next cycle.
REQ-013 In LOOKUP, a hit SHALL mean valid and tag-equal; on a hit the FSM SHALL go to UPDATE with resp_way equal to the matching way (lowest index if several match).
REQ-014 On an access miss, the victim SHALL be the lowest-index invalid way; if all ways are valid, the victim SHALL be the way with age 3 (see REQ-024). The FSM SHALL then go to FILL.
REQ-015 In FILL: fill_req SHALL be 1 and fill_way SHALL equal the victim; evict_valid SHALL equal the victim's old valid bit and evict_tag SHALL equal its old tag; all of these SHALL hold stable until fill_done.
REQ-016 fill_done SHALL be sampled only in FILL and SHALL be ignored elsewhere; it MAY be high in the first FILL cycle.
REQ-017 When fill_done is sampled, the victim's tag SHALL be written, its valid bit set to 1, and the FSM SHALL go to UPDATE.
REQ-018 In UPDATE, for an access, the accessed way's age SHALL become 0 and every way in the set whose age was below the old age SHALL increment; the FSM SHALL then return to IDLE.
REQ-019 resp_valid SHALL be a single-cycle pulse in UPDATE; latency SHALL be 2 cycles after acceptance for a hit, and 1 cycle after the fill_done cycle for a miss.
REQ-020 For an invalidate hit, the matching way's valid bit SHALL be cleared, ages SHALL be unchanged, and resp_hit=1.
REQ-021 For an invalidate miss, the FSM SHALL go LOOKUP->UPDATE with resp_hit=0 and resp_way=0; no fill and no state change SHALL occur.
REQ-022 Back-to-back requests to the same set SHALL observe all prior updates; there is no bypass hazard, because one request is outstanding at a time.

Reset
REQ-023 While rst is high (asynchronously), state SHALL be IDLE; req_ready=1; fill_req, evict_valid, resp_valid and resp_hit SHALL be 0; fill_way, resp_way and evict_tag SHALL be 0.
REQ-024 Reset SHALL clear all valid bits and set the ages of way0..way3 to 0,1,2,3 in every set.
REQ-025 Reset asserted mid-FILL SHALL drop fill_req immediately and discard the request with no response.

Configuration
REQ-026 When WAY_ALLOC_STATS_EN is defined, the block SHALL add outputs hit_cnt and miss_cnt (16 bits each), which SHALL increment on the resp_valid cycle of access hits and misses respectively, saturate at 0xFFFF, and reset to 0.
REQ-027 When WAY_ALLOC_STATS_EN is undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 After reset: access set 3, tag 0x0A5 -> miss, fill_way=0, evict_valid=0; with fill_done one cycle later -> resp_hit=0, resp_way=0.
REQ-029 Repeat the access to set 3, tag 0x0A5 -> resp_valid 2 cycles after acceptance, resp_hit=1, resp_way=0, no fill_req.
REQ-030 Fill set 5 with tags 1,2,3,4 (ways 0..3), then access tag 1, then tag 5 -> victim way 1, evict_valid=1, evict_tag=2.
REQ-031 Invalidate set 5, tag 3 -> resp_hit=1, resp_way=2; a following access to tag 9 -> fill_way=2, evict_valid=0.
REQ-032 Assert rst during FILL with fill_done held low -> fill_req=0 in the same cycle, no resp_valid, and a re-access of the same tag misses.
REQ-033 With WAY_ALLOC_STATS_EN defined, run the sequence of REQ-028..REQ-029 -> hit_cnt=1, miss_cnt=1.
